// File: rtl/uart_rx_16x.sv
// rtl/uart_rx_16x.sv - 16x-oversampled UART receiver with a 1-entry valid/ready holding register
module uart_rx_16x #(
   parameter int CLK_FREQ_HZ = 50000000,
   parameter int BAUD        = 115200,
   parameter int DATA_BITS   = 8,
   parameter int PARITY      = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx_pin,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       rx_parity_err,
   output logic       rx_frame_err,
   output logic       rx_break,
   output logic       rx_overrun,
   output logic       rx_busy
);
   localparam int DIV = (CLK_FREQ_HZ + 8 * BAUD) / (16 * BAUD);
   localparam int PW  = (DIV < 2) ? 1 : $clog2(DIV);
   localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
   localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);

   generate
      if (DIV < 2) begin : g_bad_div
         $error("uart_rx_16x: DIV must be at least 2");
      end
      if (DATA_BITS < 5 || DATA_BITS > 8 || PARITY < 0 || PARITY > 2) begin : g_bad_fmt
         $error("uart_rx_16x: unsupported frame format");
      end
   endgenerate

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE} state_t;
   state_t r_state, w_next;

   logic [1:0]    r_sync;
   logic          r_rx_prev;
   logic [PW-1:0] r_presc;
   logic [3:0]    r_cnt16;
   logic [2:0]    r_bit;
   logic [7:0]    r_shift;
   logic          r_par_bit;
   logic          r_stop_bit;
   logic          r_commit;
   logic          w_rx_s, w_fall, w_tick, w_tick16, w_par_err, w_break, w_load;

   assign w_rx_s    = r_sync[1];
   assign w_fall    = r_rx_prev & ~w_rx_s;
   assign w_tick    = (r_presc == PRESC_MAX);
   assign w_tick16  = w_tick & (r_cnt16 == 4'hF);
   assign w_par_err = (PARITY != 0) && ((^r_shift ^ r_par_bit) != (PARITY == 1));
   assign w_break   = ~r_stop_bit & (r_shift == 8'h00) & ~r_par_bit;
   assign w_load    = ~rx_valid | rx_ready;
   assign rx_busy   = (r_state != S_IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:      if (w_fall) w_next = S_START;
         S_START:     if (w_tick && r_cnt16 == 4'd7) w_next = w_rx_s ? S_IDLE : S_DATA;
         S_DATA:      if (w_tick16 && r_bit == BIT_LAST) w_next = (PARITY != 0) ? S_PARITY : S_STOP;
         S_PARITY:    if (w_tick16) w_next = S_STOP;
         // Stop=1 resyncs at mid stop so a following start edge is caught immediately
         S_STOP:      if (w_tick16) w_next = w_rx_s ? S_IDLE : S_WAIT_IDLE;
         S_WAIT_IDLE: if (w_rx_s) w_next = S_IDLE;
         default:     w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync     <= 2'b11;
         r_rx_prev  <= 1'b1;
         r_presc    <= '0;
         r_cnt16    <= '0;
         r_bit      <= '0;
         r_shift    <= '0;
         r_par_bit  <= 1'b0;
         r_stop_bit <= 1'b1;
         r_commit   <= 1'b0;
      end else begin
         r_sync    <= {r_sync[0], rx_pin};
         r_rx_prev <= w_rx_s;
         r_commit  <= 1'b0;
         if ((r_state == S_IDLE && w_fall) || w_tick) r_presc <= '0;
         else                                         r_presc <= r_presc + PW'(1);
         case (r_state)
            S_IDLE: if (w_fall) begin
               r_cnt16   <= '0;
               r_bit     <= '0;
               r_shift   <= '0;
               r_par_bit <= 1'b0;
            end
            S_START: if (w_tick) r_cnt16 <= (r_cnt16 == 4'd7) ? 4'd0 : r_cnt16 + 4'd1;
            S_DATA: if (w_tick) begin
               r_cnt16 <= r_cnt16 + 4'd1;
               if (r_cnt16 == 4'hF) begin
                  r_shift[r_bit] <= w_rx_s;
                  r_bit          <= r_bit + 3'd1;
               end
            end
            S_PARITY: if (w_tick) begin
               r_cnt16 <= r_cnt16 + 4'd1;
               if (r_cnt16 == 4'hF) r_par_bit <= w_rx_s;
            end
            S_STOP: if (w_tick) begin
               r_cnt16 <= r_cnt16 + 4'd1;
               if (r_cnt16 == 4'hF) begin
                  r_stop_bit <= w_rx_s;
                  r_commit   <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_data       <= 8'h00;
         rx_valid      <= 1'b0;
         rx_parity_err <= 1'b0;
         rx_frame_err  <= 1'b0;
         rx_break      <= 1'b0;
         rx_overrun    <= 1'b0;
      end else begin
         rx_parity_err <= 1'b0;
         rx_frame_err  <= 1'b0;
         rx_break      <= 1'b0;
         rx_overrun    <= 1'b0;
         if (r_commit) begin
            rx_parity_err <= w_par_err;
            rx_frame_err  <= ~r_stop_bit;
            rx_break      <= w_break;
            if (w_load) begin
               rx_data  <= r_shift;
               rx_valid <= 1'b1;
            end else begin
               rx_overrun <= 1'b1;
            end
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end
endmodule
